// File: rtl/pool_ctrl.sv
// pool_ctrl: control FSM for an NxN / stride-S pooling stage.
// Tracks the raster position of the incoming pixel stream, flags the pixel
// that completes each pooling window (o_next_we, one cycle later), counts
// emitted windows and hands off to the next layer with o_next_start once
// the whole image has been consumed.
module pool_ctrl #(
    parameter int IMG_DIM    = 13,
    parameter int KERNEL_DIM = 3,
    parameter int STRIDE     = 2,
    parameter int CNT_W      = $clog2(IMG_DIM*IMG_DIM+1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic                       i_pixel_we,
    output logic                       o_ready,
    input  logic                       i_next_ready,
    output logic                       o_next_we,
    output logic                       o_next_start,
    output logic [$clog2(IMG_DIM)-1:0] o_row,
    output logic [$clog2(IMG_DIM)-1:0] o_col,
    output logic [CNT_W-1:0]           o_win_cnt,
    output logic                       o_overrun
);

    localparam int RC_W = $clog2(IMG_DIM);
    localparam logic [RC_W-1:0] LAST = RC_W'(IMG_DIM - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, SIGNAL} state_t;

    state_t state;
    logic   accept;
    logic   win_hit;
    int     r_off;
    int     c_off;

    // Upstream may only push while we are idle or streaming and the next layer can take data
    assign o_ready = ((state == IDLE) || (state == STREAM)) ? i_next_ready : 1'b0;
    assign accept  = (state == STREAM) && i_pixel_we && i_next_ready;

    // Current pixel closes a window when it is the bottom-right corner of an aligned window
    always_comb begin
        r_off   = int'(o_row) - (KERNEL_DIM - 1);
        c_off   = int'(o_col) - (KERNEL_DIM - 1);
        win_hit = 1'b0;
        if ((r_off >= 0) && (c_off >= 0)) begin
            win_hit = ((r_off % STRIDE) == 0) && ((c_off % STRIDE) == 0);
        end
    end

    // Main FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            o_next_we    <= 1'b0;
            o_next_start <= 1'b0;
            o_row        <= '0;
            o_col        <= '0;
            o_win_cnt    <= '0;
            o_overrun    <= 1'b0;
        end else begin
            o_next_we    <= 1'b0;
            o_next_start <= 1'b0;

            // A write the upstream was told not to make is latched until the next image
            if (i_pixel_we && !o_ready) begin
                o_overrun <= 1'b1;
            end

            // Count each window in the cycle it is presented downstream
            if (o_next_we) begin
                o_win_cnt <= o_win_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= STREAM;
                        o_row     <= '0;
                        o_col     <= '0;
                        o_win_cnt <= '0;
                        o_overrun <= 1'b0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        o_next_we <= win_hit;
                        if (o_col == LAST) begin
                            o_col <= '0;
                            if (o_row == LAST) begin
                                o_row <= '0;
                                state <= FLUSH;
                            end else begin
                                o_row <= o_row + RC_W'(1);
                            end
                        end else begin
                            o_col <= o_col + RC_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Final window (if any) is on o_next_we this cycle; the
                    // completion pulse can follow immediately if downstream is ready
                    state        <= SIGNAL;
                    o_next_start <= i_next_ready;
                end
                SIGNAL: begin
                    if (o_next_start) begin
                        state <= IDLE;
                    end else begin
                        o_next_start <= i_next_ready;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_ctrl.sv
// Testbench for pool_ctrl: default-parameter instance driven with random
// pixel gaps against a window-enumeration model, plus a small 4x4/2x2/2
// instance checked against fixed expected window positions.
module tb_pool_ctrl;

    localparam int IMG   = 13;
    localparam int K     = 3;
    localparam int S     = 2;
    localparam int OUT   = (IMG - K) / S + 1;
    localparam int RC_W  = $clog2(IMG);
    localparam int CNT_W = $clog2(IMG*IMG+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start, pixel_we, next_ready;
    logic             ready, next_we, next_start, overrun;
    logic [RC_W-1:0]  row, col;
    logic [CNT_W-1:0] win_cnt;

    logic             s_start, s_pixel_we, s_next_ready;
    logic             s_ready, s_next_we, s_next_start, s_overrun;
    logic [1:0]       s_row, s_col;
    logic [4:0]       s_win_cnt;

    int checks = 0;
    int errors = 0;
    int pix;
    int pulses;
    bit exp_win [IMG*IMG];

    pool_ctrl dut (
        .clk(clk), .rst(rst), .i_start(start), .i_pixel_we(pixel_we),
        .o_ready(ready), .i_next_ready(next_ready), .o_next_we(next_we),
        .o_next_start(next_start), .o_row(row), .o_col(col),
        .o_win_cnt(win_cnt), .o_overrun(overrun)
    );

    pool_ctrl #(.IMG_DIM(4), .KERNEL_DIM(2), .STRIDE(2)) dut_small (
        .clk(clk), .rst(rst), .i_start(s_start), .i_pixel_we(s_pixel_we),
        .o_ready(s_ready), .i_next_ready(s_next_ready), .o_next_we(s_next_we),
        .o_next_start(s_next_start), .o_row(s_row), .o_col(s_col),
        .o_win_cnt(s_win_cnt), .o_overrun(s_overrun)
    );

    always #5 clk = ~clk;

    // Begin a new image on the default instance; the model restarts at pixel 0
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pix = 0;
        pulses = 0;
        checks++;
        if ({row, col, win_cnt, overrun, next_we} !== '0) begin
            errors++;
            $display("FAIL start_clear: got row=%0d col=%0d win=%0d ovr=%b we=%b, want all 0",
                     row, col, win_cnt, overrun, next_we);
        end
        $display("start: image begun");
    endtask

    // Push n pixels with random idle gaps, checking position and window flags
    task automatic stream(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (next_we !== 1'b0) begin
                    errors++;
                    $display("FAIL we_gap: got %b want 0 (pix %0d)", next_we, pix);
                end
            end
            checks++;
            if (row !== RC_W'(pix / IMG) || col !== RC_W'(pix % IMG)) begin
                errors++;
                $display("FAIL coord: got (%0d,%0d) want (%0d,%0d)", row, col, pix / IMG, pix % IMG);
            end
            pixel_we = 1'b1;
            @(negedge clk);
            pixel_we = 1'b0;
            checks++;
            if (next_we !== exp_win[pix]) begin
                errors++;
                $display("FAIL next_we: pix %0d got %b want %b", pix, next_we, exp_win[pix]);
            end
            if (next_we === 1'b1) pulses++;
            $display("pixel %0d (%0d,%0d) gap %0d next_we %b", pix, pix / IMG, pix % IMG, gap, next_we);
            pix++;
        end
    endtask

    // After the last pixel: FLUSH then a single completion pulse with next_ready high
    task automatic finish_image();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b want 0", ready);
        end
        @(negedge clk);
        checks++;
        if (next_start !== 1'b1 || next_we !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL signal: got start=%b we=%b ready=%b want 1 0 0", next_start, next_we, ready);
        end
        checks++;
        if (int'(win_cnt) != OUT*OUT || pulses != OUT*OUT) begin
            errors++;
            $display("FAIL win_total: got cnt=%0d pulses=%0d want %0d", win_cnt, pulses, OUT*OUT);
        end
        @(negedge clk);
        checks++;
        if (next_start !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL back_idle: got start=%b ready=%b want 0 1", next_start, ready);
        end
        $display("image done: windows %0d", win_cnt);
    endtask

    task automatic test_reset();
        checks++;
        if ({next_we, next_start, row, col, win_cnt, overrun} !== '0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got we=%b st=%b row=%0d col=%0d win=%0d ovr=%b rdy=%b",
                     next_we, next_start, row, col, win_cnt, overrun, ready);
        end
        checks++;
        if ({s_next_we, s_next_start, s_row, s_col, s_win_cnt, s_overrun} !== '0) begin
            errors++;
            $display("FAIL reset_small: got nonzero outputs");
        end
        $display("reset: outputs checked");
    endtask

    // 4x4 image, 2x2 windows, stride 2: windows close on pixels 5, 7, 13, 15
    task automatic test_small();
        logic [15:0] hits;
        hits = 16'b1010_0000_1010_0000;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int p = 0; p < 16; p++) begin
            s_pixel_we = 1'b1;
            @(negedge clk);
            checks++;
            if (s_next_we !== hits[p] || s_next_start !== 1'b0) begin
                errors++;
                $display("FAIL small_we: pix %0d got we=%b st=%b want %b 0", p, s_next_we, s_next_start, hits[p]);
            end
            $display("small pixel %0d next_we %b", p, s_next_we);
        end
        s_pixel_we = 1'b0;
        @(negedge clk);
        checks++;
        if (s_next_start !== 1'b1 || s_next_we !== 1'b0 || s_win_cnt !== 5'd4) begin
            errors++;
            $display("FAIL small_done: got st=%b we=%b win=%0d want 1 0 4", s_next_start, s_next_we, s_win_cnt);
        end
        @(negedge clk);
        checks++;
        if (s_next_start !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL small_idle: got st=%b rdy=%b want 0 1", s_next_start, s_ready);
        end
    endtask

    task automatic test_full_image();
        do_start();
        stream(IMG*IMG, 3);
        finish_image();
    endtask

    task automatic test_back_to_back();
        for (int img = 0; img < 2; img++) begin
            do_start();
            stream(IMG*IMG, 0);
            finish_image();
        end
    endtask

    // Downstream stalls from FLUSH onward: SIGNAL must wait, then pulse once
    task automatic test_flush_hold();
        do_start();
        stream(IMG*IMG, 1);
        next_ready = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_flush_ready: got %b want 0", ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (next_start !== 1'b0 || ready !== 1'b0 || next_we !== 1'b0) begin
                errors++;
                $display("FAIL hold: cycle %0d got st=%b rdy=%b we=%b want 0 0 0", c, next_start, ready, next_we);
            end
            $display("hold cycle %0d next_start %b", c, next_start);
        end
        next_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (next_start !== 1'b1 || int'(win_cnt) != OUT*OUT) begin
            errors++;
            $display("FAIL hold_release: got st=%b win=%0d want 1 %0d", next_start, win_cnt, OUT*OUT);
        end
        @(negedge clk);
        checks++;
        if (next_start !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_idle: got st=%b rdy=%b want 0 1", next_start, ready);
        end
    endtask

    // Write while not ready: no advance, sticky flag survives to the next start
    task automatic test_overrun();
        logic [CNT_W-1:0] win_before;
        do_start();
        stream(20, 2);
        win_before = win_cnt;
        next_ready = 1'b0;
        pixel_we = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ovr_ready: got %b want 0", ready);
        end
        @(negedge clk);
        pixel_we = 1'b0;
        next_ready = 1'b1;
        checks++;
        if (overrun !== 1'b1 || next_we !== 1'b0 || win_cnt !== win_before ||
            row !== RC_W'(pix / IMG) || col !== RC_W'(pix % IMG)) begin
            errors++;
            $display("FAIL ovr_hold: got ovr=%b we=%b win=%0d (%0d,%0d) want 1 0 %0d (%0d,%0d)",
                     overrun, next_we, win_cnt, row, col, win_before, pix / IMG, pix % IMG);
        end
        $display("overrun write: flag %b", overrun);
        stream(IMG*IMG - 20, 2);
        finish_image();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got %b want 1", overrun);
        end
    endtask

    // Start pulse mid-image must not disturb position or window count
    task automatic test_start_ignored();
        logic [CNT_W-1:0] win_before;
        do_start();
        stream(30, 1);
        win_before = win_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (row !== RC_W'(pix / IMG) || col !== RC_W'(pix % IMG) || win_cnt !== win_before || overrun !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: got (%0d,%0d) win=%0d ovr=%b want (%0d,%0d) %0d 0",
                     row, col, win_cnt, overrun, pix / IMG, pix % IMG, win_before);
        end
        $display("mid-image start ignored");
        stream(IMG*IMG - 30, 1);
        finish_image();
    endtask

    // Asynchronous reset mid-image, then a clean full image
    task automatic test_reset_mid();
        do_start();
        stream(50, 1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({next_we, next_start, row, col, win_cnt, overrun} !== '0) begin
            errors++;
            $display("FAIL async_reset: got we=%b st=%b row=%0d col=%0d win=%0d ovr=%b want all 0",
                     next_we, next_start, row, col, win_cnt, overrun);
        end
        $display("async reset mid-image");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        stream(IMG*IMG, 2);
        finish_image();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pixel_we = 1'b0;
        next_ready = 1'b1;
        s_start = 1'b0;
        s_pixel_we = 1'b0;
        s_next_ready = 1'b1;
        pix = 0;
        pulses = 0;
        // Mark the bottom-right pixel of every pooling window
        for (int p = 0; p < IMG*IMG; p++) exp_win[p] = 1'b0;
        for (int wr = 0; wr < OUT; wr++)
            for (int wc = 0; wc < OUT; wc++)
                exp_win[(wr*S + K - 1)*IMG + (wc*S + K - 1)] = 1'b1;

        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_small();
        test_full_image();
        test_back_to_back();
        test_flush_hold();
        test_overrun();
        test_start_ignored();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_DIM, 13, input image width and height in pixels.
REQ-002 The block SHALL have parameter KERNEL_DIM, 3, pooling window edge N (window NxN).
REQ-003 The block SHALL have parameter STRIDE, 2, window step in rows and columns.
REQ-004 The block SHALL have parameter CNT_W, $clog2(IMG_DIM*IMG_DIM+1), width of the window counter.
REQ-005 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 The block SHALL have port i_start  input  1  one-cycle pulse, begin a new image.
REQ-008 The block SHALL have port i_pixel_we  input  1  one pixel (all channels) written to the pooling FIFO this cycle.
REQ-009 The block SHALL have port o_ready  output  1  upstream may write a pixel this cycle.
REQ-010 The block SHALL have port i_next_ready  input  1  downstream layer can accept data.
REQ-011 The block SHALL have port o_next_we  output  1  current pooled window valid; write to next layer.
REQ-012 The block SHALL have port o_next_start  output  1  one-cycle pulse, pooled image complete.
REQ-013 The block SHALL have port o_row, o_col  output  $clog2(IMG_DIM) each  coordinates of the next pixel expected.
REQ-014 The block SHALL have port o_win_cnt  output  CNT_W  windows emitted for the current image.
REQ-015 The block SHALL have port o_overrun  output  1  sticky error: i_pixel_we seen while o_ready=0.

Function
REQ-016 The block SHALL implement states IDLE, STREAM, FLUSH, SIGNAL.
REQ-017 IDLE: i_start=1 -> STREAM next edge; o_row, o_col, o_win_cnt, o_overrun cleared on that edge.
REQ-018 i_start outside IDLE SHALL be ignored, no state or counter change.
REQ-019 o_ready SHALL equal i_next_ready while state is IDLE or STREAM, else 0 (combinational).
REQ-020 STREAM: accepted pixel = i_pixel_we & o_ready; each increments o_col; o_col at IMG_DIM-1 wraps to 0 and o_row increments.
REQ-021 Pixel write with o_ready=0 SHALL not advance counters and SHALL set o_overrun until next accepted i_start or reset.
REQ-022 Accepted pixel at (r,c) SHALL register o_next_we=1 next cycle iff r>=KERNEL_DIM-1, c>=KERNEL_DIM-1, (r-KERNEL_DIM+1) mod STRIDE=0, (c-KERNEL_DIM+1) mod STRIDE=0; latency exactly 1 cycle, width 1 cycle.
REQ-023 o_win_cnt SHALL increment on each cycle o_next_we=1; total per image (OUT_DIM)^2, OUT_DIM=(IMG_DIM-KERNEL_DIM)/STRIDE+1 (integer division).
REQ-024 Accepted pixel at (IMG_DIM-1,IMG_DIM-1) SHALL move STREAM->FLUSH; o_row, o_col wrap to 0.
REQ-025 FLUSH SHALL last one cycle (carries final o_next_we if REQ-022 applies) then go to SIGNAL.
REQ-026 SIGNAL: o_next_start=1 for exactly one cycle once i_next_ready=1, then IDLE; waits in SIGNAL while i_next_ready=0.
REQ-027 o_next_we and o_next_start SHALL never be high in the same cycle.
REQ-028 Counter arithmetic SHALL be unsigned; no saturation needed as counts are bounded by REQ-023.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, o_next_we=0, o_next_start=0, o_row=0, o_col=0, o_win_cnt=0, o_overrun=0, from any state including mid-image.
REQ-030 After rst deasserts, the first edge SHALL behave as IDLE; a pending pulse lost during reset is not replayed.

Verification
REQ-031 IMG_DIM=4, KERNEL_DIM=2, STRIDE=2, i_next_ready=1, 16 back-to-back pixels -> o_next_we one cycle after pixels 5,7,13,15; o_win_cnt=4; o_next_start 2 cycles after pixel 15.
REQ-032 Default params, 169 pixels with random gaps -> 36 o_next_we pulses, one o_next_start, o_win_cnt=36.
REQ-033 i_next_ready=0 at last pixel's FLUSH, held 5 cycles -> SIGNAL holds, o_next_start only in the cycle after i_next_ready rises; o_ready=0 throughout.
REQ-034 i_pixel_we with i_next_ready=0 mid-STREAM -> counters unchanged, o_overrun=1 until next i_start.
REQ-035 rst pulsed after 50 pixels -> all outputs 0 immediately; new i_start plus full image gives correct counts.
REQ-036 i_start pulsed during STREAM -> ignored, counters continue, window positions unaffected.
